// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// ALU code map, muldiv op encodings, FSM states and iteration count.
package alu_muldiv_seq_pkg;

    localparam int XLEN       = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    // Shared ALU opcode map; only add and sub are driven by the sequencer.
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOR  = 5'b00101;
    localparam logic [4:0] OP_SLT  = 5'b00110;
    localparam logic [4:0] OP_SLTU = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_LUI  = 5'b01011;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABS_A  = 3'd1,
        ST_ABS_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5,
        ST_DONE   = 3'd6
    } md_state_e;

    function automatic logic md_is_div(input md_op_e o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. Borrows the shared execute-stage
// ALU for every add/sub and keeps the 64-bit result in HI/LO.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [4:0]  alu_opselect,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_res,
    input  logic        alu_c_out
);

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             carry_lo_q, carry_lo_d;
    logic             dbz_q, dbz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is_div;
    logic        is_signed;
    logic        sign_diff;
    logic [31:0] div_x;
    logic        accept;

    assign is_div    = md_is_div(op_q);
    assign is_signed = md_is_signed(op_q);
    assign sign_diff = neg_a_q ^ neg_b_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        a_d          = a_q;
        b_d          = b_q;
        neg_a_d      = neg_a_q;
        neg_b_d      = neg_b_q;
        carry_lo_d   = carry_lo_q;
        dbz_d        = dbz_q;
        cnt_d        = cnt_q;
        alu_opselect = OP_ADD;
        alu_x        = '0;
        alu_y        = '0;
        div_x        = {hi_q[30:0], lo_q[31]};
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d       = md_op_e'(op);
                    a_d        = rs_val;
                    b_d        = rt_val;
                    neg_a_d    = 1'b0;
                    neg_b_d    = 1'b0;
                    carry_lo_d = 1'b0;
                    dbz_d      = 1'b0;
                    // A zero divisor short-circuits straight to DONE.
                    if (md_is_div(md_op_e'(op)) && (rt_val == '0)) begin
                        hi_d    = rs_val;
                        lo_d    = DZ_QUOTIENT;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ABS_A;
                    end
                end
            end

            ST_ABS_A: begin
                alu_opselect = OP_SUB;
                alu_y        = a_q;
                if (is_signed && a_q[31]) begin
                    a_d     = alu_res;
                    neg_a_d = 1'b1;
                end
                state_d = ST_ABS_B;
            end

            ST_ABS_B: begin
                alu_opselect = OP_SUB;
                alu_y        = b_q;
                if (is_signed && b_q[31]) begin
                    b_d     = alu_res;
                    neg_b_d = 1'b1;
                end
                // Both algorithms start with HI cleared and |a| in LO.
                hi_d    = '0;
                lo_d    = a_q;
                cnt_d   = CNT_W'(ITERATIONS - 1);
                state_d = ST_ITER;
            end

            ST_ITER: begin
                if (is_div) begin
                    alu_opselect = OP_SUB;
                    alu_x        = div_x;
                    alu_y        = b_q;
                    // hi[31] means the shifted partial remainder is 33 bits wide,
                    // so it always exceeds the divisor.
                    accept = hi_q[31] | alu_c_out;
                    hi_d   = accept ? alu_res : div_x;
                    lo_d   = {lo_q[30:0], accept};
                end else begin
                    alu_opselect = OP_ADD;
                    alu_x        = hi_q;
                    alu_y        = b_q;
                    if (lo_q[0]) begin
                        {hi_d, lo_d} = {alu_c_out, alu_res, lo_q[31:1]};
                    end else begin
                        {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
                    end
                end
                if (cnt_q == '0) begin
                    state_d = ST_FIX_LO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_FIX_LO: begin
                if (is_div) begin
                    alu_opselect = OP_SUB;
                    alu_y        = lo_q;
                    if (sign_diff) begin
                        lo_d = alu_res;
                    end
                end else begin
                    // Low half of the 64-bit two's complement negate.
                    alu_opselect = OP_ADD;
                    alu_x        = ~lo_q;
                    alu_y        = 32'd1;
                    if (sign_diff) begin
                        lo_d       = alu_res;
                        carry_lo_d = alu_c_out;
                    end
                end
                state_d = ST_FIX_HI;
            end

            ST_FIX_HI: begin
                if (is_div) begin
                    // Remainder takes the dividend's sign.
                    alu_opselect = OP_SUB;
                    alu_y        = hi_q;
                    if (neg_a_q) begin
                        hi_d = alu_res;
                    end
                end else begin
                    alu_opselect = OP_ADD;
                    alu_x        = ~hi_q;
                    alu_y        = {31'b0, carry_lo_q};
                    if (sign_diff) begin
                        hi_d = alu_res;
                    end
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= MD_MULT;
            hi_q       <= '0;
            lo_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            carry_lo_q <= 1'b0;
            dbz_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            a_q        <= a_d;
            b_q        <= b_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            carry_lo_q <= carry_lo_d;
            dbz_q      <= dbz_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural model of the shared ALU.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  alu_opselect;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [31:0] alu_res;
    logic        alu_c_out;

    int checks = 0;
    int errors = 0;

    alu_muldiv_seq #(.DZ_QUOTIENT(32'hFFFF_FFFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (div_by_zero),
        .hi           (hi),
        .lo           (lo),
        .alu_opselect (alu_opselect),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_res      (alu_res),
        .alu_c_out    (alu_c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: add, and sub as x + ~y + 1 so carry-out 1 means no borrow.
    always_comb begin
        logic [32:0] sum;
        sum = '0;
        case (alu_opselect)
            5'b00000: sum = {1'b0, alu_x} + {1'b0, alu_y};
            5'b00001: sum = {1'b0, alu_x} + {1'b0, ~alu_y} + 33'd1;
            default:  sum = '0;
        endcase
        alu_res   = sum[31:0];
        alu_c_out = sum[32];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at #1 into an IDLE cycle; the start is accepted at the next edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rs_val = '0;
        rt_val = '0;
    endtask

    // n0 is the cycle index (relative to the accepting edge) of the current cycle.
    task automatic wait_done(input int n0, output int lat, output int busy_low);
        int n;
        n = n0;
        busy_low = 0;
        while ((done !== 1'b1) && (n < 200)) begin
            if (busy !== 1'b1) busy_low++;
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b1) busy_low++;
        lat = (done === 1'b1) ? n : -1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] eh,
                          input logic [31:0] el, input logic edz);
        int lat;
        int bl;
        @(posedge clk);
        #1;
        check({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
        issue(o, a, b);
        wait_done(1, lat, bl);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_gap"}, bl, 32'd0);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        check({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, edz});
        check({tag, " done_aluop"}, {27'b0, alu_opselect}, 32'd0);
        check({tag, " done_alux"}, alu_x, 32'd0);
    endtask

    initial begin
        int lat;
        int bl;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst dbz", {31'b0, div_by_zero}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst aluop", {27'b0, alu_opselect}, 32'd0);
        check("rst alux", alu_x, 32'd0);
        check("rst aluy", alu_y, 32'd0);
        rst = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 37, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_n3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 37, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 37, 32'h4000_0000, 32'h0, 1'b0);
        run_op("div_n7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 37, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7dn2", 2'b10, 32'd7, 32'hFFFF_FFFE, 37, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_big3", 2'b11, 32'h8000_0000, 32'd3, 37, 32'd2, 32'h2AAA_AAAA, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 37, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu_dz", 2'b11, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);

        // Next accepted start clears the divide-by-zero flag.
        @(posedge clk);
        #1;
        issue(2'b01, 32'd6, 32'd7);
        check("dz_clear dbz", {31'b0, div_by_zero}, 32'd0);
        wait_done(1, lat, bl);
        check("dz_clear latency", lat, 32'd37);
        check("dz_clear lo", lo, 32'd42);
        check("dz_clear hi", hi, 32'd0);

        // A start pulsed mid-operation must be ignored.
        @(posedge clk);
        #1;
        issue(2'b00, 32'd7, 32'hFFFF_FFFE);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd100;
        rt_val = 32'd0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done(11, lat, bl);
        check("ignore latency", lat, 32'd37);
        check("ignore busy_gap", bl, 32'd0);
        check("ignore hi", hi, 32'hFFFF_FFFF);
        check("ignore lo", lo, 32'hFFFF_FFF2);
        check("ignore dbz", {31'b0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        check("ignore no_requeue", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a divide.
        issue(2'b10, 32'd100, 32'd7);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        check("midrst pre_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst done", {31'b0, done}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op("post_rst", 2'b11, 32'd100, 32'd7, 37, 32'd2, 32'd14, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
